// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch controller: PC stepping, imem requests, tagged response FIFO
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_ctrl #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        fetch_misalign,
`endif
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(FIFO_DEPTH);

   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] of_cnt_q, of_cnt_d;
   logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [PTR_W-1:0] of_wr_q, of_wr_d, of_rd_q, of_rd_d;
   logic [31:0]      tag_mem      [FIFO_DEPTH];
   logic [31:0]      of_pc_mem    [FIFO_DEPTH];
   logic [31:0]      of_instr_mem [FIFO_DEPTH];
   logic             pop, credit, misalign, push, rv_ok, of_wr, of_rd;
   logic [CNT_W:0]   committed;

   assign if_valid = (of_cnt_q != '0);
   assign if_instr = if_valid ? of_instr_mem[of_rd_q] : '0;
   assign if_pc    = if_valid ? of_pc_mem[of_rd_q] : '0;

   always_comb begin
      pop       = if_valid & if_ready;
      // in-flight plus buffered slots, counting the entry leaving this cycle as free
      committed = {1'b0, outstanding_q} + {1'b0, of_cnt_q} - (CNT_W+1)'(pop);
      credit    = (committed < DEPTH_W);
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign  = reset_n & ~redirect_valid & (pc[1:0] != 2'b00);
`else
      misalign  = 1'b0;
`endif
      imem_req  = reset_n & credit & ~redirect_valid & ~misalign;
      imem_addr = {pc[31:2], 2'b00};
      push      = imem_req & imem_gnt;

      if (!reset_n)            next_pc = pc;
      else if (redirect_valid) next_pc = redirect_pc;
      else if (push)           next_pc = pc + 32'd4;
      else                     next_pc = pc;

      rv_ok = imem_rvalid & (outstanding_q != '0);
      of_wr = rv_ok & (discard_q == '0) & ~redirect_valid;
      of_rd = pop & ~redirect_valid;

      outstanding_d = outstanding_q + CNT_W'(push) - CNT_W'(rv_ok);
      tag_wr_d      = tag_wr_q + PTR_W'(push);
      tag_rd_d      = tag_rd_q + PTR_W'(rv_ok);

      discard_d = discard_q;
      if (redirect_valid)
         discard_d = outstanding_q - CNT_W'(rv_ok);
      else if (rv_ok && (discard_q != '0))
         discard_d = discard_q - CNT_W'(1);

      if (redirect_valid) begin
         of_cnt_d = '0;
         of_wr_d  = '0;
         of_rd_d  = '0;
      end else begin
         of_cnt_d = of_cnt_q + CNT_W'(of_wr) - CNT_W'(of_rd);
         of_wr_d  = of_wr_q + PTR_W'(of_wr);
         of_rd_d  = of_rd_q + PTR_W'(of_rd);
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_misalign = misalign;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outstanding_q <= '0;
         discard_q     <= '0;
         of_cnt_q      <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         of_wr_q       <= '0;
         of_rd_q       <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         of_cnt_q      <= of_cnt_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         of_wr_q       <= of_wr_d;
         of_rd_q       <= of_rd_d;
      end
   end

   // storage arrays need no reset: outputs are masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push)
         tag_mem[tag_wr_q] <= pc;
      if (of_wr) begin
         of_pc_mem[of_wr_q]    <= tag_mem[tag_rd_q];
         of_instr_mem[of_wr_q] <= imem_rdata;
      end
   end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch-side controller that sits between program_counter and instruction memory, and drives the next_pc that program_counter loads every cycle. Issues one imem request per accepted PC and holds the PC (next_pc = pc) while stalled. Buffers in-order responses in a small FIFO tagged with their PC and presents them to the IF/ID stage with a valid/ready handshake. On branch/flush redirect, discards in-flight and buffered fetches.

Parameters:
FIFO_DEPTH, 2, entries in the {pc, instr} output buffer; power of 2, >=2; also caps in-flight requests.
CNT_W, $clog2(FIFO_DEPTH+1), width of the outstanding, discard and count counters (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
pc  in  32  current PC from program_counter.
next_pc  out  32  value program_counter loads at the next edge (combinational).
redirect_valid  in  1  branch-taken/flush from EX.
redirect_pc  in  32  redirect target.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  response valid; in order, max one per cycle, earliest 1 cycle after gnt.
imem_rdata  in  32  instruction word.
if_valid  out  1  instruction available to IF/ID.
if_instr  out  32  instruction word.
if_pc  out  32  PC of if_instr.
if_ready  in  1  IF/ID accepts.

Behaviour:
- Reset (reset_n=0, asynchronous): outstanding=0, discard=0, FIFO empty. if_valid=0, imem_req=0, if_instr=0, if_pc=0. next_pc=pc is passed through while in reset.
- pop = if_valid & if_ready.
- Credit: credit = (outstanding + fifo_count - pop) < FIFO_DEPTH, using registered counts. This gives full throughput with 1-cycle memory latency.
- imem_req = credit & ~redirect_valid. imem_addr = {pc[31:2], 2'b00}.
- next_pc priority:
  1. redirect_valid -> redirect_pc.
  2. imem_req & imem_gnt -> pc + 32'd4 (modulo 2^32; 0xFFFFFFFC wraps to 0).
  3. Otherwise -> pc (hold).
- PC tag FIFO: on req&gnt, push pc into an internal tag queue of FIFO_DEPTH entries.
- outstanding counter: +1 on req&gnt, -1 on rvalid. Both in the same cycle leaves it unchanged.
- Response, non-redirect cycle: rvalid with discard=0 writes {tag head, rdata} into the output FIFO and pops the tag; discard>0 pops the tag, drops the data and decrements discard.
- if_valid asserts the cycle after the write (registered FIFO output). Gnt at N, rvalid at N+1 -> if_valid at N+2.
- rvalid with outstanding=0 is a protocol error: ignored, no state change.
- redirect_valid at edge:
  - Output FIFO flushed; if_valid=0 next cycle (pop that cycle is ignored).
  - discard <= outstanding - rvalid; a same-cycle rvalid is dropped and its tag popped.
  - Tag queue keeps only the entries to be discarded.
  - Repeated redirects recompute the same way; discard <= outstanding always holds.
- Output FIFO: one write and one pop in the same cycle is legal and the count is unchanged. Overflow cannot occur because of the credit rule.
- if_instr/if_pc hold their value while if_valid & ~if_ready; they are stable until accepted.

Optional Feature:
FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit), reset 0.
  - If pc[1:0]!=0 and no redirect: imem_req=0, next_pc=pc (hold), fetch_misalign=1 combinationally until a redirect arrives.
  - Buffered instructions still drain.
- Not defined: port absent; pc[1:0] ignored (address forced word-aligned); next_pc = pc+4 as normal.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 1 outstanding and 1 buffered -> if_valid=0, imem_req=0 immediately; after release with pc=0, imem_addr=0, next_pc=4 on gnt.
- Streaming: 1-cycle memory, if_ready=1, pc from 0 -> gnt every cycle; if_pc sequence 0,4,8,C, one per cycle starting 2 cycles after first gnt.
- Back-pressure: if_ready=0 for 6 cycles -> at most FIFO_DEPTH=2 requests granted, then imem_req=0 and next_pc=pc held. if_instr/if_pc stable; the stream resumes with no loss or duplication when if_ready=1.
- Redirect with in-flight: 2 outstanding, redirect_valid with redirect_pc=0x100 in the same cycle as one rvalid -> next_pc=0x100, imem_req=0 that cycle; both old responses dropped; next if_pc=0x100.
- Wrap: pc=0xFFFFFFFC granted -> next_pc=0x00000000; if_pc=0xFFFFFFFC delivered.
- With FETCH_MISALIGN_TRAP_EN: pc=0x102 -> fetch_misalign=1, imem_req=0, next_pc=0x102; redirect to 0x200 -> fetch_misalign=0, fetch resumes at 0x200.
